// File: rtl/fetch_defs.sv
// Shared definitions for the instruction-fetch stage: NOP/HALT encodings, FSM states
// and the {inst, inc_pc} entry format.
package fetch_defs;

    localparam int unsigned InstW    = 16;
    localparam logic [15:0] NopInst  = 16'h0800;
    localparam logic [4:0]  HALT_OPC = 5'b00000;

    typedef enum logic [1:0] {
        StFetch,
        StDrain,
        StHaltWait,
        StHalted
    } fetch_state_e;

    typedef struct packed {
        logic [InstW-1:0] inst;
        logic [InstW-1:0] inc_pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Output slot plus one-entry skid for the fetch stage; entries are {inst, inc_pc}.
// Flush beats push and pop; the skid only fills when the slot is held.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        flush,
    output logic        slot_valid,
    output logic [31:0] slot_data,
    output logic        skid_valid
);

    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_data_q, slot_data_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_data_q, skid_data_d;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            slot_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            // Skid (older) advances first; a new push lands behind it.
            slot_valid_d = skid_valid_q;
            slot_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            if (push) begin
                if (skid_valid_q) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = push_data;
                end else begin
                    slot_valid_d = 1'b1;
                    slot_data_d  = push_data;
                end
            end
        end else if (push) begin
            if (!slot_valid_q) begin
                slot_valid_d = 1'b1;
                slot_data_d  = push_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_q <= 1'b0;
            slot_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign slot_valid = slot_valid_q;
    assign slot_data  = slot_data_q;
    assign skid_valid = skid_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// WISC instruction-fetch stage: owns the PC, drives imem via rd/done, delivers {inst, PC+2}.
// Optional saturating perf counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_defs::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = NopInst
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] inst_out,
    output logic [15:0] inc_pc_out,
    output logic        inst_valid,
    output logic        halted,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] stall_cycles,
    output logic [15:0] fetched_cnt,
`endif
    output logic        err
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  drain_addr_q, drain_addr_d;
    logic         err_q, err_d;

    logic         push, pop, flush, fetch_ok, accept;
    logic         slot_valid, skid_valid;
    logic [31:0]  slot_data;
    fetch_entry_t push_entry, slot_entry;

    fetch_skid_buf u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .slot_valid(slot_valid),
        .slot_data (slot_data),
        .skid_valid(skid_valid)
    );

    assign slot_entry = slot_data;
    assign push_entry = '{inst: imem_data, inc_pc: pc_q + 16'd2};

    // A full skid blocks issue, so at most one request is ever in flight.
    assign fetch_ok  = (state_q == StFetch) && !skid_valid;
    assign imem_rd   = !rst && ((state_q == StDrain) || (fetch_ok && !pc_q[0]));
    assign imem_addr = (state_q == StDrain) ? drain_addr_q : pc_q;
    assign accept    = imem_rd && imem_done;
    assign pop       = slot_valid && !stall_id;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        err_d        = err_q;
        push         = 1'b0;
        flush        = 1'b0;
        if (redirect_en) begin
            flush = 1'b1;
            pc_d  = redirect_pc;
            if (imem_rd && !imem_done) begin
                state_d      = StDrain;
                drain_addr_d = imem_addr;
            end else begin
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (fetch_ok && pc_q[0]) begin
                        err_d   = 1'b1;
                        state_d = StHalted;
                    end else if (accept) begin
                        push = 1'b1;
                        pc_d = pc_q + 16'd2;
                        if (imem_data[15:11] == HALT_OPC) state_d = StHaltWait;
                    end
                end
                StDrain:    if (accept) state_d = StFetch;
                // HALT is the youngest entry, so it is consumed when the skid is empty.
                StHaltWait: if (pop && !skid_valid) state_d = StHalted;
                StHalted:   state_d = StHalted;
                default:    state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            err_q        <= err_d;
        end
    end

    assign inst_out   = slot_valid ? slot_entry.inst : NOP_INST;
    assign inc_pc_out = slot_valid ? slot_entry.inc_pc : 16'h0000;
    assign inst_valid = slot_valid;
    assign halted     = (state_q == StHalted);
    assign err        = err_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] fetched_cnt_q, fetched_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fetched_cnt_d  = fetched_cnt_q;
        if (imem_rd && !imem_done && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (push && (fetched_cnt_q != 16'hFFFF)) fetched_cnt_d = fetched_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            fetched_cnt_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fetched_cnt_q  <= fetched_cnt_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign fetched_cnt  = fetched_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed segments push expected deliveries, a monitor
// pops and compares on every consumed slot.
module tb_fetch_unit;

    logic        clk, rst, stall_id, redirect_en;
    logic [15:0] redirect_pc, imem_addr, imem_data, inst_out, inc_pc_out;
    logic        imem_rd, imem_done, inst_valid, halted, err;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cycles, fetched_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          lat;
    int          mcnt;
    logic [15:0] halt_addr;
    logic [31:0] exp_q[$];

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall_id   (stall_id),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .imem_done  (imem_done),
        .inst_out   (inst_out),
        .inc_pc_out (inc_pc_out),
        .inst_valid (inst_valid),
        .halted     (halted),
`ifdef FETCH_PERF_CNT_EN
        .stall_cycles(stall_cycles),
        .fetched_cnt (fetched_cnt),
`endif
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: data = 4000+addr except HALT at halt_addr; done after lat cycles of rd.
    always_comb begin
        imem_done = imem_rd && (mcnt == lat - 1);
        imem_data = (imem_addr == halt_addr) ? 16'h0000 : 16'h4000 + imem_addr;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) mcnt <= 0;
        else if (imem_rd && !imem_done) mcnt <= mcnt + 1;
        else mcnt <= 0;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [15:0] start, input int n, input logic [15:0] hpc);
        for (int i = 0; i < n; i++) exp_q.push_back({16'h4000 + start + 16'(2 * i),
                                                     start + 16'(2 * i + 2)});
        exp_q.push_back({16'h0000, hpc + 16'd2});
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        redirect_en = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect_en = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int max);
        int n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, {15'd0, halted}, 16'd1);
    endtask

    // Monitor: compare every consumed slot against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && imem_rd && imem_addr[0]) begin
                errors++;
                $display("FAIL misaligned_req addr %h issued, required none", imem_addr);
            end
            if (!rst && inst_valid && !stall_id && !redirect_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_delivery got %h/%h required none",
                             inst_out, inc_pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_out !== e[31:16] || inc_pc_out !== e[15:0]) begin
                        errors++;
                        $display("FAIL delivery got %h/%h expected %h/%h",
                                 inst_out, inc_pc_out, e[31:16], e[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        int n;
        rst = 1'b1; stall_id = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        lat = 1; halt_addr = 16'h000A;
        repeat (2) @(negedge clk);
        chk("rst_inst_valid", {15'd0, inst_valid}, 16'd0);
        chk("rst_inst_out", inst_out, 16'h0800);
        chk("rst_inc_pc", inc_pc_out, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_imem_rd", {15'd0, imem_rd}, 16'd0);

        // Zero-wait stream 0000..0008 then HALT at 000A.
        expect_seq(16'h0000, 5, 16'h000A);
        rst = 1'b0;
        #1;
        chk("zw_rd0", {15'd0, imem_rd}, 16'd1);
        chk("zw_addr0", imem_addr, 16'h0000);
        @(negedge clk);
        chk("zw_addr1", imem_addr, 16'h0002);
        chk("zw_valid1", {15'd0, inst_valid}, 16'd1);
        @(negedge clk);
        chk("zw_addr2", imem_addr, 16'h0004);
        wait_halted("halt_a", 30);
        repeat (3) @(negedge clk);
        chk("halt_rd_off", {15'd0, imem_rd}, 16'd0);
        chk("halt_still", {15'd0, halted}, 16'd1);

        // Resume at 0020 with 3-cycle memory; HALT at 0026.
        lat = 3; halt_addr = 16'h0026;
        expect_seq(16'h0020, 3, 16'h0026);
        redirect_to(16'h0020);
        for (int i = 0; i < 3; i++) begin
            chk("lat3_rd", {15'd0, imem_rd}, 16'd1);
            chk("lat3_addr", imem_addr, 16'h0020);
            chk("lat3_empty", {15'd0, inst_valid}, 16'd0);
            @(negedge clk);
        end
        chk("lat3_next_addr", imem_addr, 16'h0022);
        chk("lat3_valid", {15'd0, inst_valid}, 16'd1);
        wait_halted("halt_b", 60);

        // Redirect to 0100 while the 0006 request is outstanding; 0004 and 0006 are squashed.
        halt_addr = 16'h0104;
        exp_q.push_back({16'h4000, 16'h0002});
        exp_q.push_back({16'h4002, 16'h0004});
        expect_seq(16'h0100, 2, 16'h0104);
        redirect_to(16'h0000);
        n = 0;
        while (!(imem_rd && imem_addr == 16'h0006) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reach_0006", imem_addr, 16'h0006);
        redirect_to(16'h0100);
        chk("flush_valid", {15'd0, inst_valid}, 16'd0);
        chk("drain_addr", imem_addr, 16'h0006);
        chk("drain_rd", {15'd0, imem_rd}, 16'd1);
        n = 0;
        while (!imem_rd || imem_addr == 16'h0006) begin
            if (n >= 20) break;
            @(negedge clk);
            n++;
        end
        chk("post_redirect_addr", imem_addr, 16'h0100);
        wait_halted("halt_c", 60);

        // Stall for 4 cycles with zero-wait memory; HALT at 004C.
        lat = 1; halt_addr = 16'h004C;
        expect_seq(16'h0040, 6, 16'h004C);
        redirect_to(16'h0040);
        n = 0;
        while (!inst_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        stall_id = 1'b1;
        held = inst_out;
        chk("stall_head", held, 16'h4040);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_inst_hold", inst_out, held);
            chk("stall_rd_off", {15'd0, imem_rd}, 16'd0);
        end
        stall_id = 1'b0;
        wait_halted("halt_d", 40);

        // Misaligned redirect: no request, err and halted.
        redirect_to(16'h0013);
        chk("mis_rd", {15'd0, imem_rd}, 16'd0);
        @(negedge clk);
        chk("mis_err", {15'd0, err}, 16'd1);
        chk("mis_halted", {15'd0, halted}, 16'd1);
        @(negedge clk);
        chk("err_sticky", {15'd0, err}, 16'd1);

        chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
